// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the round controller: state encoding, field widths, saturating kill add.
package game_state_ctrl_pkg;

    localparam int unsigned GS_W    = 3;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned KILLS_W = 3;
    localparam int unsigned TIMER_W = 8;

    // Encoding is also read by the pixel mux for the game-over/win overlay colour
    typedef enum logic [GS_W-1:0] {
        GS_IDLE = 3'd0,
        GS_PLAY = 3'd1,
        GS_HIT  = 3'd2,
        GS_OVER = 3'd3,
        GS_WIN  = 3'd4
    } game_state_e;

    // Add this cycle's kills to the running count, clamping at the win threshold
    function automatic logic [KILLS_W-1:0] sat_kills(
        input logic [KILLS_W-1:0] kills,
        input logic [KILLS_W-1:0] inc,
        input logic [KILLS_W-1:0] limit
    );
        logic [KILLS_W:0] sum;
        sum = {1'b0, kills} + {1'b0, inc};
        return (sum >= {1'b0, limit}) ? limit : sum[KILLS_W-1:0];
    endfunction

endpackage

// File: rtl/game_state_ctrl_kill_popcount.sv
// Counts how many enemy kill pulses are high in the current cycle.
module game_state_ctrl_kill_popcount
    import game_state_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES = 6
) (
    input  logic [NUM_ENEMIES-1:0] enemy_killed,
    output logic [KILLS_W-1:0]     count_c
);

    // Straight bit sum; NUM_ENEMIES <= 7 keeps the result within 3 bits
    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            count_c = count_c + KILLS_W'(enemy_killed[i]);
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Round controller: lives, kill count, invulnerability timer and the IDLE/PLAY/HIT/OVER/WIN FSM.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BLINK_SHIFT   = 3,
    parameter int unsigned NUM_ENEMIES   = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   death_signal,
    input  logic [NUM_ENEMIES-1:0] enemy_killed,
    output logic                   game_over,
    output logic                   game_won,
    output logic [LIVES_W-1:0]     lives,
    output logic [KILLS_W-1:0]     kills,
    output logic                   respawn,
    output logic                   invulnerable,
    output logic                   bomberman_hide,
    output logic [GS_W-1:0]        state
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [KILLS_W-1:0] KILLS_WIN  = KILLS_W'(NUM_ENEMIES);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(INVULN_FRAMES);

    game_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_d;
    logic [KILLS_W-1:0] kills_d, kill_pop_c, kills_sat_c;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               respawn_d;

    game_state_ctrl_kill_popcount #(
        .NUM_ENEMIES (NUM_ENEMIES)
    ) u_kill_popcount (
        .enemy_killed (enemy_killed),
        .count_c      (kill_pop_c)
    );

    assign kills_sat_c = sat_kills(kills, kill_pop_c, KILLS_WIN);
    assign state       = state_q;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= GS_IDLE;
            lives          <= LIVES_INIT;
            kills          <= '0;
            timer_q        <= '0;
            respawn        <= 1'b0;
            game_over      <= 1'b0;
            game_won       <= 1'b0;
            invulnerable   <= 1'b0;
            bomberman_hide <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives          <= lives_d;
            kills          <= kills_d;
            timer_q        <= timer_d;
            respawn        <= respawn_d;
            game_over      <= (state_d == GS_OVER);
            game_won       <= (state_d == GS_WIN);
            invulnerable   <= (state_d == GS_HIT);
            bomberman_hide <= (state_d == GS_HIT) ? timer_d[BLINK_SHIFT] : 1'b0;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d   = state_q;
        lives_d   = lives;
        kills_d   = kills;
        timer_d   = timer_q;
        respawn_d = 1'b0;
        unique case (state_q)
            GS_IDLE, GS_OVER, GS_WIN: begin
                if (start) begin
                    state_d   = GS_PLAY;
                    lives_d   = LIVES_INIT;
                    kills_d   = '0;
                    timer_d   = '0;
                    respawn_d = 1'b1;
                end
            end
            GS_PLAY: begin
                kills_d = kills_sat_c;
                if (kills_sat_c == KILLS_WIN) begin
                    state_d = GS_WIN;
                // Overlap is ignored while the respawn pulse is out so the pulse stays single-cycle
                end else if (death_signal && !respawn) begin
                    if (lives > LIVES_W'(1)) begin
                        state_d   = GS_HIT;
                        lives_d   = lives - LIVES_W'(1);
                        timer_d   = TIMER_INIT;
                        respawn_d = 1'b1;
                    end else begin
                        state_d = GS_OVER;
                        lives_d = '0;
                    end
                end
            end
            GS_HIT: begin
                kills_d = kills_sat_c;
                if (kills_sat_c == KILLS_WIN) begin
                    state_d = GS_WIN;
                    timer_d = '0;
                end else if (frame_tick) begin
                    if (timer_q <= TIMER_W'(1)) begin
                        state_d = GS_PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            default: begin
                state_d = GS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       start;
    logic       death_signal;
    logic [5:0] enemy_killed;
    logic       game_over;
    logic       game_won;
    logic [2:0] lives;
    logic [2:0] kills;
    logic       respawn;
    logic       invulnerable;
    logic       bomberman_hide;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    game_state_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_tick     (frame_tick),
        .start          (start),
        .death_signal   (death_signal),
        .enemy_killed   (enemy_killed),
        .game_over      (game_over),
        .game_won       (game_won),
        .lives          (lives),
        .kills          (kills),
        .respawn        (respawn),
        .invulnerable   (invulnerable),
        .bomberman_hide (bomberman_hide),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_death();
        death_signal = 1'b1;
        step();
        death_signal = 1'b0;
    endtask

    initial begin
        int tval;
        reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0; death_signal = 1'b0; enemy_killed = '0;
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 3);
        chk("rst_kills", kills, 0);
        chk("rst_respawn", respawn, 0);
        chk("rst_over", game_over, 0);
        chk("rst_inv", invulnerable, 0);
        chk("rst_hide", bomberman_hide, 0);
        reset_n = 1'b1;
        step();
        chk("idle_hold", state, 0);

        // start with simultaneous death: start wins
        start = 1'b1; death_signal = 1'b1;
        step();
        start = 1'b0; death_signal = 1'b0;
        chk("start_state", state, 1);
        chk("start_lives", lives, 3);
        chk("start_kills", kills, 0);
        chk("start_respawn", respawn, 1);
        step();
        chk("start_respawn_clr", respawn, 0);
        pulse_start();
        chk("start_in_play_ign", state, 1);
        chk("start_in_play_resp", respawn, 0);

        // first hit
        pulse_death();
        chk("hit1_state", state, 2);
        chk("hit1_lives", lives, 2);
        chk("hit1_respawn", respawn, 1);
        chk("hit1_inv", invulnerable, 1);
        chk("hit1_hide", bomberman_hide, 1);
        death_signal = 1'b1;
        step();
        chk("hit1_respawn_clr", respawn, 0);
        chk("hit1_hide_notick", bomberman_hide, 1);
        // timer runs on ticks only; hide follows bit 3 of remaining frames
        for (int k = 1; k < 120; k++) begin
            tick();
            tval = 120 - k;
            chk("hit_hide", bomberman_hide, (tval >> 3) & 1);
            chk("hit_lives_held", lives, 2);
            step();
            chk("hit_state_held", state, 2);
        end
        tick();
        chk("hit1_exit_state", state, 1);
        chk("hit1_exit_inv", invulnerable, 0);
        chk("hit1_exit_hide", bomberman_hide, 0);
        chk("hit1_exit_lives", lives, 2);
        // overlap still present costs another life
        step();
        death_signal = 1'b0;
        chk("hit2_state", state, 2);
        chk("hit2_lives", lives, 1);
        chk("hit2_respawn", respawn, 1);
        ticks(120);
        chk("hit2_exit_state", state, 1);

        // third hit ends the game
        pulse_death();
        chk("over_state", state, 3);
        chk("over_lives", lives, 0);
        chk("over_flag", game_over, 1);
        chk("over_respawn", respawn, 0);
        chk("over_inv", invulnerable, 0);
        death_signal = 1'b1; enemy_killed = 6'b111111;
        step();
        death_signal = 1'b0; enemy_killed = '0;
        chk("over_hold", state, 3);
        chk("over_kills_ign", kills, 0);
        pulse_start();
        chk("restart_state", state, 1);
        chk("restart_lives", lives, 3);
        chk("restart_over", game_over, 0);
        chk("restart_respawn", respawn, 1);
        step();

        // kills accumulate to a win and saturate
        enemy_killed = 6'b000111;
        step();
        chk("kills3", kills, 3);
        chk("kills3_state", state, 1);
        enemy_killed = 6'b111000;
        step();
        chk("kills6", kills, 6);
        chk("win_state", state, 4);
        chk("win_flag", game_won, 1);
        enemy_killed = 6'b111111; death_signal = 1'b1;
        step();
        enemy_killed = '0; death_signal = 1'b0;
        chk("win_kills_sat", kills, 6);
        chk("win_hold", state, 4);
        chk("win_lives", lives, 3);

        // win reached from HIT with a saturating sum (3 + 6)
        pulse_start();
        chk("restart2_kills", kills, 0);
        chk("restart2_won", game_won, 0);
        step();
        enemy_killed = 6'b010101;
        step();
        enemy_killed = '0;
        chk("kills3b", kills, 3);
        pulse_death();
        chk("hit3_state", state, 2);
        enemy_killed = 6'b111111;
        step();
        enemy_killed = '0;
        chk("hit_win_state", state, 4);
        chk("hit_win_kills", kills, 6);
        chk("hit_win_inv", invulnerable, 0);

        // kills=5, lives=1: last kill and death together -> win
        pulse_start();
        step();
        enemy_killed = 6'b011111;
        step();
        enemy_killed = '0;
        chk("kills5", kills, 5);
        pulse_death();
        ticks(120);
        pulse_death();
        ticks(120);
        chk("lives1_state", state, 1);
        chk("lives1", lives, 1);
        enemy_killed = 6'b100000; death_signal = 1'b1;
        step();
        enemy_killed = '0; death_signal = 1'b0;
        chk("tie_state", state, 4);
        chk("tie_lives", lives, 1);
        chk("tie_respawn", respawn, 0);
        chk("tie_over", game_over, 0);

        // asynchronous reset in the middle of HIT
        pulse_start();
        step();
        pulse_death();
        ticks(70);
        chk("mid_hit_state", state, 2);
        chk("mid_hit_hide", bomberman_hide, 0);
        tick();
        chk("mid_hit_hide49", bomberman_hide, 0);
        ticks(8);
        chk("mid_hit_hide41", bomberman_hide, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_lives", lives, 3);
        chk("arst_kills", kills, 0);
        chk("arst_inv", invulnerable, 0);
        chk("arst_hide", bomberman_hide, 0);
        chk("arst_respawn", respawn, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
